pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 stall  in  1  downstream cannot accept an instruction; holds fetch.
REQ-005 br_take  in  1  taken-branch redirect, valid for one cycle.
REQ-006 br_base  in  32  PC+4 of the redirecting instruction.
REQ-007 br_off  in  32  word offset already shifted left by 2 (sign-extended imm <<2).
REQ-008 jmp  in  1  jump redirect, valid for one cycle.
REQ-009 jmp_index  in  26  jump instruction index field.
REQ-010 imem_req  out  1  instruction-memory read request.
REQ-011 imem_addr  out  32  word-aligned fetch address.
REQ-012 imem_ack  in  1  memory has returned data for the current request.
REQ-013 fetch_valid  out  1  returned instruction is architecturally valid this cycle.
REQ-014 pc  out  32  address of the instruction currently being fetched.
REQ-015 pc_plus4  out  32  pc + 4, modulo 2^32.

Function
REQ-016 Branch target SHALL be br_base + br_off, modulo 2^32 (no overflow detection).
REQ-017 Jump target SHALL be {br_base[31:28], jmp_index, 2'b00}.
REQ-018 If jmp and br_take are both high, jump SHALL win.
REQ-019 FSM states SHALL be BOOT, REQ, HOLD.
REQ-020 BOOT: imem_req=0; SHALL move to REQ on the next edge unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=pc; address SHALL stay stable until imem_ack, regardless of stall.
REQ-022 REQ with imem_ack: fetch_valid=1 unless a redirect is present this cycle or a pending redirect is held, in which case fetch_valid=0 (squash).
REQ-023 Next pc on ack SHALL be: current-cycle redirect target; else pending target (pending cleared); else pc+4.
REQ-024 On ack, next state SHALL be HOLD if stall=1, else REQ (back-to-back fetch, one instruction per cycle at best).
REQ-025 REQ without ack: a redirect SHALL be latched into a pending register; a later redirect SHALL overwrite an earlier one.
REQ-026 HOLD: imem_req=0, fetch_valid=0; a redirect SHALL update pc directly; SHALL return to REQ when stall=0.
REQ-027 imem_addr[1:0] SHALL always be 2'b00; target bits [1:0] are discarded.
REQ-028 pc wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000.
REQ-029 fetch_valid SHALL be asserted only in a cycle with imem_ack=1 in REQ.
REQ-030 imem_ack outside REQ SHALL be ignored.

Reset
REQ-031 On rst_n=0, immediately: state=BOOT, pc=RESET_PC, pending cleared, imem_req=0, fetch_valid=0.
REQ-032 Reset mid-request SHALL abandon the outstanding fetch; no late ack SHALL produce fetch_valid.
REQ-033 Deassertion SHALL be taken synchronously at the next clk edge.

Structure
REQ-034 FSM state encoding and RESET_PC default SHALL live in the shared cpu package.
REQ-035 Target computation SHALL be one combinational sub-module, npc_target, producing the selected redirect target and a redirect flag.
REQ-036 fetch_valid SHALL be a combinational function of registered state, imem_ack and redirect inputs; pc, state and pending SHALL be registers.

Verification
REQ-037 Reset release, ack every cycle -> imem_addr 0x0, 0x4, 0x8 on consecutive REQ cycles, fetch_valid=1 each.
REQ-038 pc=0x100 waiting, br_take with br_base=0x104, br_off=0xFFFF_FFF0 two cycles before ack -> ack squashed, next imem_addr=0xF4.
REQ-039 jmp and br_take together, br_base=0x8000_0010, jmp_index=0x000_0040 -> next imem_addr=0x8000_0100.
REQ-040 stall=1 held at ack for 3 cycles -> imem_req=0 three cycles, pc=prev+4, then REQ resumes at that address.
REQ-041 pc=0xFFFF_FFFC, ack, no redirect -> next imem_addr=0x0000_0000.
REQ-042 rst_n pulsed low while waiting for ack at 0x40 -> outputs reset immediately; ack after release before REQ gives fetch_valid=0; first fetch at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared fetch-unit types: FSM encoding, reset PC, redirect type.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

    localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
    localparam logic [31:0] c_word_mask  = 32'hFFFF_FFFC;

    localparam logic [1:0]  c_st_boot    = 2'd0;
    localparam logic [1:0]  c_st_req     = 2'd1;
    localparam logic [1:0]  c_st_hold    = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } redirect_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory request/acknowledge bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_npc_target.sv
`default_nettype none
// ============================================================================
// Module      : npc_target
// Description : Selects the redirect target (jump over branch), word aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_target
    import pc_fetch_unit_pkg::*;
(
    input  wire logic        br_take,
    input  wire logic [31:0] br_base,
    input  wire logic [31:0] br_off,
    input  wire logic        jmp,
    input  wire logic [25:0] jmp_index,
    output redirect_t        redir
);

    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic [31:0] w_raw_target;

    always_comb begin
        w_br_target  = br_base + br_off;
        w_jmp_target = {br_base[31:28], jmp_index, 2'b00};
        w_raw_target = jmp ? w_jmp_target : w_br_target;
        redir.valid  = jmp | br_take;
        redir.target = w_raw_target & c_word_mask;
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program-counter sequencer with request/ack instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        stall,
    input  wire logic        br_take,
    input  wire logic [31:0] br_base,
    input  wire logic [31:0] br_off,
    input  wire logic        jmp,
    input  wire logic [25:0] jmp_index,
    pc_fetch_unit_if.master  imem,
    output logic             fetch_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4
);

    localparam logic [31:0] c_reset_aligned = RESET_PC & c_word_mask;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    redirect_t   r_pend;
    redirect_t   w_redir;
    logic [31:0] w_pc_plus4;

    npc_target u_npc_target (
        .br_take   (br_take),
        .br_base   (br_base),
        .br_off    (br_off),
        .jmp       (jmp),
        .jmp_index (jmp_index),
        .redir     (w_redir)
    );

    assign w_pc_plus4     = r_pc + 32'd4;
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign imem.imem_req  = (r_state == c_st_req);
    assign imem.imem_addr = r_pc;

    // A returning instruction is squashed when any redirect is in flight.
    assign fetch_valid = (r_state == c_st_req) && imem.imem_ack
                         && !w_redir.valid && !r_pend.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_boot;
            r_pc    <= c_reset_aligned;
            r_pend  <= '0;
        end else begin
            case (r_state)
                c_st_boot: begin
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (imem.imem_ack) begin
                        if (w_redir.valid) begin
                            r_pc <= w_redir.target;
                        end else if (r_pend.valid) begin
                            r_pc <= r_pend.target;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                        r_pend  <= '0;
                        r_state <= stall ? c_st_hold : c_st_req;
                    end else if (w_redir.valid) begin
                        // Address must not move mid-request; remember latest redirect.
                        r_pend <= w_redir;
                    end
                end
                c_st_hold: begin
                    if (w_redir.valid) begin
                        r_pc <= w_redir.target;
                    end
                    if (!stall) begin
                        r_state <= c_st_req;
                    end
                end
                default: begin
                    r_state <= c_st_boot;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed + random self-checking bench with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_take;
    logic [31:0] br_base;
    logic [31:0] br_off;
    logic        jmp;
    logic [25:0] jmp_index;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 = waiting out boot, 1 = request outstanding, 2 = holding.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    bit          m_pendv;

    pc_fetch_unit_if u_if ();

    pc_fetch_unit #(.RESET_PC(RST_PC)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_take     (br_take),
        .br_base     (br_base),
        .br_off      (br_off),
        .jmp         (jmp),
        .jmp_index   (jmp_index),
        .imem        (u_if.master),
        .fetch_valid (fetch_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input bit j, input logic [31:0] base,
                                               input logic [31:0] off, input logic [25:0] idx);
        if (j) return {base[31:28], idx, 2'b00};
        return (base + off) & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RST_PC;
        m_pend  = '0;
        m_pendv = 1'b0;
    endtask

    // One clock: drive, check outputs mid-cycle, advance the model, cross the edge.
    task automatic cyc(input bit st, input bit br, input logic [31:0] base, input logic [31:0] off,
                       input bit j, input logic [25:0] idx, input bit ack);
        bit          redir;
        logic [31:0] t;
        stall          = st;
        br_take        = br;
        br_base        = base;
        br_off         = off;
        jmp            = j;
        jmp_index      = idx;
        u_if.imem_ack  = ack;
        #1;
        redir = br | j;
        t     = ref_target(j, base, off, idx);
        check("imem_req", {31'b0, u_if.imem_req}, {31'b0, m_phase == 1});
        if (m_phase == 1) check("imem_addr", u_if.imem_addr, m_pc);
        check("fetch_valid", {31'b0, fetch_valid},
              {31'b0, (m_phase == 1) && ack && !redir && !m_pendv});
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (ack) begin
                m_pc    = redir ? t : (m_pendv ? m_pend : m_pc + 32'd4);
                m_pendv = 1'b0;
                m_phase = st ? 2 : 1;
            end else if (redir) begin
                m_pend  = t;
                m_pendv = 1'b1;
            end
        end else begin
            if (redir) m_pc = t;
            if (!st) m_phase = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input bit st, input bit ack);
        cyc(st, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, ack);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; br_take = 1'b0; br_base = '0; br_off = '0;
        jmp = 1'b0; jmp_index = '0; u_if.imem_ack = 1'b1;
        model_reset();
        #12;
        check("rst_req", {31'b0, u_if.imem_req}, 32'h0);
        check("rst_fv", {31'b0, fetch_valid}, 32'h0);
        check("rst_pc", pc, RST_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Boot cycle then back-to-back fetches 0x0, 0x4, 0x8.
        plain(1'b0, 1'b1);
        check("seq_a0", u_if.imem_addr, 32'h0);
        plain(1'b0, 1'b1);
        check("seq_a4", u_if.imem_addr, 32'h4);
        plain(1'b0, 1'b1);
        check("seq_a8", u_if.imem_addr, 32'h8);
        plain(1'b0, 1'b1);

        // Jump to 0x100, then a branch arrives two cycles before the ack.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 26'h40, 1'b1);
        check("jmp_100", u_if.imem_addr, 32'h100);
        cyc(1'b0, 1'b1, 32'h104, 32'hFFFF_FFF0, 1'b0, 26'h0, 1'b0);
        plain(1'b0, 1'b0);
        check("pend_hold_addr", u_if.imem_addr, 32'h100);
        plain(1'b0, 1'b1);
        check("br_f4", u_if.imem_addr, 32'hF4);

        // Jump beats branch.
        cyc(1'b0, 1'b1, 32'h8000_0010, 32'h0000_1234, 1'b1, 26'h40, 1'b1);
        check("jmp_wins", u_if.imem_addr, 32'h8000_0100);

        // Stall at ack for three cycles.
        plain(1'b1, 1'b1);
        check("stall_pc", pc, 32'h8000_0104);
        plain(1'b1, 1'b1);
        plain(1'b1, 1'b0);
        plain(1'b0, 1'b1);
        check("stall_resume_req", {31'b0, u_if.imem_req}, 32'h1);
        check("stall_resume_addr", u_if.imem_addr, 32'h8000_0104);

        // Later pending redirect overwrites earlier one.
        cyc(1'b0, 1'b1, 32'h200, 32'h10, 1'b0, 26'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h3000_0000, 32'h0, 1'b1, 26'h123, 1'b0);
        plain(1'b0, 1'b1);
        check("pend_overwrite", u_if.imem_addr, 32'h3000_048C);

        // Wrap from the top of the address space; low target bits discarded.
        cyc(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, 26'h0, 1'b1);
        check("top_addr", u_if.imem_addr, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        plain(1'b0, 1'b1);
        check("wrap_addr", u_if.imem_addr, 32'h0);

        // Redirect while holding updates pc directly.
        plain(1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h500, 32'h0, 1'b0, 26'h0, 1'b1);
        check("hold_redir", u_if.imem_addr, 32'h500);

        // Reset while waiting for ack at 0x40.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 26'h10, 1'b1);
        plain(1'b0, 1'b0);
        check("wait_40", u_if.imem_addr, 32'h40);
        rst_n = 1'b0;
        u_if.imem_ack = 1'b1;
        #1;
        model_reset();
        check("mid_rst_req", {31'b0, u_if.imem_req}, 32'h0);
        check("mid_rst_fv", {31'b0, fetch_valid}, 32'h0);
        check("mid_rst_pc", pc, RST_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        plain(1'b0, 1'b1);
        check("post_rst_addr", u_if.imem_addr, RST_PC);
        check("post_rst_req", {31'b0, u_if.imem_req}, 32'h1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0,
                $urandom,
                $urandom,
                $urandom_range(0, 19) == 0,
                26'($urandom),
                $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
